// File: rtl/pcs_tx_encode_ctrl_pkg.sv
// Shared types and constants for the 10GBASE-R transmit encode sequencer.
package pcs_tx_encode_ctrl_pkg;

    // Block classification of one XGMII word
    typedef enum logic [2:0] {
        TT_C = 3'd0,
        TT_S = 3'd1,
        TT_T = 3'd2,
        TT_D = 3'd3,
        TT_E = 3'd4
    } ttype_e;

    // Transmit state machine states
    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_C    = 3'd1,
        ST_D    = 3'd2,
        ST_T    = 3'd3,
        ST_E    = 3'd4
    } tx_state_e;

    localparam logic [7:0] CH_IDLE  = 8'h07;
    localparam logic [7:0] CH_ERR   = 8'hFE;
    localparam logic [7:0] CH_START = 8'hFB;
    localparam logic [7:0] CH_TERM  = 8'hFD;
    localparam logic [7:0] CH_SEQ_A = 8'h9C;
    localparam logic [7:0] CH_SEQ_B = 8'h5C;

    // Error block: eight /E/ characters in a control block
    localparam logic [65:0] EBLOCK = {{8{7'h1E}}, 8'h1E, 2'b01};
    // Local-fault ordered-set block
    localparam logic [65:0] LBLOCK = {28'h0, 4'h0, 24'h010000, 8'h4B, 2'b01};

    // A control lane that may legally pad a control block
    function automatic logic ctl_ok(input logic [7:0] ch);
        return (ch == CH_IDLE) || (ch == CH_ERR);
    endfunction

    // Next TX state from current state, current block type and look-ahead type
    function automatic tx_state_e next_state(input tx_state_e s, input ttype_e t, input ttype_e n);
        logic term_ok;
        tx_state_e ns;
        term_ok = (t == TT_T) && ((n == TT_C) || (n == TT_S));
        case (s)
            ST_D: ns = (t == TT_D) ? ST_D : (term_ok ? ST_T : ST_E);
            ST_E: begin
                if (t == TT_D)      ns = ST_D;
                else if (t == TT_C) ns = ST_C;
                else if (term_ok)   ns = ST_T;
                else                ns = ST_E;
            end
            default: ns = (t == TT_C) ? ST_C : ((t == TT_S) ? ST_D : ST_E);
        endcase
        return ns;
    endfunction

endpackage

// File: rtl/pcs_tx_encode_ctrl_ttype_classify.sv
// Combinational classification of a 72-bit XGMII word into C/S/T/D/E.
module pcs_tx_ttype_classify
    import pcs_tx_encode_ctrl_pkg::*;
(
    input  logic [71:0] xgmii_word,
    output logic [2:0]  t_type
);

    logic [7:0]      ctrl;
    logic [7:0][7:0] lane;
    logic [7:0]      lane_ok;
    logic [7:0]      term_hit;

    assign ctrl = xgmii_word[7:0];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            // Terminate in lane gi: control bits gi..7 set, lanes above it idle/error
            localparam logic [7:0] TERM_CTRL  = 8'hFF << gi;
            localparam logic [7:0] ABOVE_MASK = 8'hFF << (gi + 1);

            assign lane[gi]     = xgmii_word[8*gi+8 +: 8];
            assign lane_ok[gi]  = ctl_ok(lane[gi]);
            assign term_hit[gi] = (ctrl == TERM_CTRL) && (lane[gi] == CH_TERM) &&
                                  ((lane_ok & ABOVE_MASK) == ABOVE_MASK);
        end
    endgenerate

    // Priority decode; the categories are disjoint so order only sets the default
    always_comb begin
        t_type = TT_E;
        if (ctrl == 8'h00)
            t_type = TT_D;
        else if ((ctrl == 8'h01) && (lane[0] == CH_START))
            t_type = TT_S;
        else if (((ctrl == 8'hFF) && (&lane_ok)) ||
                 ((ctrl == 8'h01) && ((lane[0] == CH_SEQ_A) || (lane[0] == CH_SEQ_B))))
            t_type = TT_C;
        else if (|term_hit)
            t_type = TT_T;
    end

endmodule

// File: rtl/pcs_tx_encode_ctrl.sv
// TX sequencer around the 64b/66b encoder: one-word look-ahead, clause-49
// TX state machine, error-block substitution and local-fault forcing.
module pcs_tx_encode_ctrl
    import pcs_tx_encode_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [71:0]      xgmii_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [71:0]      enc_xgmii_out,
    input  logic [65:0]      enc_block_in,
    input  logic             force_lf,
    output logic [65:0]      tx_block_out,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [CNT_W-1:0] err_block_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             cur_valid_reg;
    ttype_e           cur_type_reg;
    logic [65:0]      cur_block_reg;
    tx_state_e        state_reg;
    tx_state_e        state_next;
    logic [65:0]      tx_block_reg;
    logic             tx_valid_reg;
    logic [CNT_W-1:0] err_cnt_reg;

    logic [2:0]       new_type_raw;
    ttype_e           new_type;
    logic             out_free;
    logic             accept;

    // The encoder sees the incoming word directly; its block is captured on accept
    assign enc_xgmii_out = xgmii_in;

    pcs_tx_ttype_classify u_classify (
        .xgmii_word (xgmii_in),
        .t_type     (new_type_raw)
    );

    assign new_type   = ttype_e'(new_type_raw);
    assign out_free   = !tx_valid_reg || tx_ready;
    assign in_ready   = force_lf || !cur_valid_reg || out_free;
    assign accept     = in_valid && in_ready;
    // Decision for the held word uses the arriving word as look-ahead
    assign state_next = next_state(state_reg, cur_type_reg, new_type);

    assign tx_block_out  = tx_block_reg;
    assign tx_valid      = tx_valid_reg;
    assign err_block_cnt = err_cnt_reg;

    // Pipeline slot, state machine, output register and error counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_valid_reg <= 1'b0;
            cur_type_reg  <= TT_E;
            cur_block_reg <= '0;
            state_reg     <= ST_INIT;
            tx_block_reg  <= '0;
            tx_valid_reg  <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            if (tx_valid_reg && tx_ready)
                tx_valid_reg <= 1'b0;

            if (force_lf) begin
                // Inputs are swallowed; the pipeline restarts from INIT on release
                state_reg     <= ST_INIT;
                cur_valid_reg <= 1'b0;
                if (out_free) begin
                    tx_block_reg <= LBLOCK;
                    tx_valid_reg <= 1'b1;
                end
            end else if (accept) begin
                cur_valid_reg <= 1'b1;
                cur_type_reg  <= new_type;
                cur_block_reg <= enc_block_in;
                // in_ready guarantees the output register is free when cur is valid
                if (cur_valid_reg) begin
                    state_reg    <= state_next;
                    tx_valid_reg <= 1'b1;
                    if (state_next == ST_E) begin
                        tx_block_reg <= EBLOCK;
                        if (err_cnt_reg != {CNT_W{1'b1}})
                            err_cnt_reg <= err_cnt_reg + CNT_ONE;
                    end else begin
                        tx_block_reg <= cur_block_reg;
                    end
                end
            end
        end
    end

endmodule
